// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for a 5-stage pipeline.
// Drives en/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the
// PC write enable. Flush has priority over en in every latch.
//
// State table:
//   RUN    | normal issue; stalls, bubbles and squashes per hazard
//   DRAIN  | halt seen in EX; younger work squashed, halt advances to WB
//   HALTED | core stopped, sticky until reset
//
// Ports:
//   CLK, nRST (sync, active-low)
//   ihit, dhit                 memory handshakes
//   exmem_dREN/dWEN/brtaken    MEM-stage status
//   idex_MemToReg/wsel/halt    EX-stage status
//   ifid_rs/rt                 ID-stage sources
//   memwb_halt                 halt reached WB
//   pc_en, *_en, *_flush       latch controls
//   halted                     sticky stop indication
//   stall_cnt/flush_cnt/cyc_cnt present only with PIPE_PERF_CNT_EN defined
module pipeline_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             exmem_dREN,
   input  logic             exmem_dWEN,
   input  logic             exmem_brtaken,
   input  logic             idex_MemToReg,
   input  logic [REG_W-1:0] idex_wsel,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             idex_halt,
   input  logic             memwb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
`ifdef PIPE_PERF_CNT_EN
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] cyc_cnt,
`endif
   output logic             halted
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic dwait;
   logic lduse;
   logic br_flush;

   assign dwait = (exmem_dREN | exmem_dWEN) & ~dhit;
   assign lduse = idex_MemToReg & (idex_wsel != '0) &
                  ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

   always_ff @(posedge CLK) begin
      if (!nRST) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      halted      = 1'b0;
      br_flush    = 1'b0;

      if (!nRST) begin
         state_d     = ST_RUN;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (dwait) begin
                  // full freeze: every latch holds, nothing lost
               end else if (exmem_brtaken) begin
                  br_flush = 1'b1;
               end else if (lduse) begin
                  idex_flush = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
               end else if (!ihit) begin
                  ifid_flush = 1'b1;
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
               end else begin
                  pc_en    = 1'b1;
                  ifid_en  = 1'b1;
                  idex_en  = 1'b1;
                  exmem_en = 1'b1;
                  memwb_en = 1'b1;
               end
               // a halt can reach WB without passing DRAIN after a flush race
               if (memwb_halt)
                  state_d = ST_HALTED;
               else if (idex_halt && !dwait && !exmem_brtaken)
                  state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (dwait) begin
                  // full freeze
               end else if (exmem_brtaken) begin
                  br_flush = 1'b1;
               end else begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
               end
               if (memwb_halt)
                  state_d = ST_HALTED;
               else if (!dwait && exmem_brtaken)
                  state_d = ST_RUN;
            end
            ST_HALTED: begin
               halted = 1'b1;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase

         // taken branch retires through MEM/WB; everything younger is squashed
         if (br_flush) begin
            pc_en       = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
         end
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, cyc_cnt_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         cyc_cnt_q   <= '0;
      end else if (state_q != ST_HALTED) begin
         if (cyc_cnt_q != '1)
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
         if (!pc_en && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (br_flush && flush_cnt_q != '1)
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign cyc_cnt   = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

   logic       CLK = 1'b0;
   logic       nRST, ihit, dhit, exmem_dREN, exmem_dWEN, exmem_brtaken;
   logic       idex_MemToReg, idex_halt, memwb_halt;
   logic [4:0] idex_wsel, ifid_rs, ifid_rt;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt, cyc_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   // {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush, halted}
   localparam logic [9:0] O_RST   = 10'b0_0000_1111_0;
   localparam logic [9:0] O_FRZ   = 10'b0_0000_0000_0;
   localparam logic [9:0] O_BR    = 10'b1_0001_1110_0;
   localparam logic [9:0] O_LDU   = 10'b0_0011_0100_0;
   localparam logic [9:0] O_NOI   = 10'b0_0111_1000_0;
   localparam logic [9:0] O_NORM  = 10'b1_1111_0000_0;
   localparam logic [9:0] O_DRAIN = 10'b0_0011_1100_0;
   localparam logic [9:0] O_HALT  = 10'b0_0000_0000_1;

   logic [9:0] sb_q[$];
   logic [9:0] obs, exp_v;

   pipeline_ctrl dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
      .exmem_brtaken(exmem_brtaken), .idex_MemToReg(idex_MemToReg),
      .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .idex_halt(idex_halt), .memwb_halt(memwb_halt),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
`ifdef PIPE_PERF_CNT_EN
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .cyc_cnt(cyc_cnt),
`endif
      .halted(halted)
   );

   always #5 CLK = ~CLK;

   task automatic clear_in();
      ihit = 1'b1; dhit = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
      exmem_brtaken = 1'b0; idex_MemToReg = 1'b0; idex_halt = 1'b0;
      memwb_halt = 1'b0; idex_wsel = '0; ifid_rs = '0; ifid_rt = '0;
   endtask

   // expectation pushed when the stimulus is applied, popped at the sample
   // point mid-cycle, then the clock edge commits the cycle.
   task automatic cyc(input string tag, input logic [9:0] e);
      sb_q.push_back(e);
      @(negedge CLK);
      obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush, halted};
      exp_v = sb_q.pop_front();
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      clear_in();
      nRST = 1'b0;
      #1;
      cyc("reset0", O_RST);
      cyc("reset1", O_RST);
      nRST = 1'b1;
      cyc("run0", O_NORM);
      cyc("run1", O_NORM);
      nRST = 1'b0;
      cyc("rst_mid", O_RST);
      nRST = 1'b1;
      cyc("run_after_rst", O_NORM);

      // data-memory wait, three cycles then hit
      exmem_dREN = 1'b1;
      cyc("dwait0", O_FRZ);
      cyc("dwait1", O_FRZ);
      cyc("dwait2", O_FRZ);
      dhit = 1'b1;
      cyc("dhit", O_NORM);
      clear_in();
      exmem_dWEN = 1'b1;
      cyc("store_wait", O_FRZ);
      clear_in();

      // load-use on rt, then load moves on
      idex_MemToReg = 1'b1; idex_wsel = 5'd5; ifid_rt = 5'd5;
      cyc("lduse_rt", O_LDU);
      idex_MemToReg = 1'b0;
      cyc("lduse_done", O_NORM);
      idex_MemToReg = 1'b1; idex_wsel = 5'd7; ifid_rs = 5'd7; ifid_rt = 5'd1;
      cyc("lduse_rs", O_LDU);
      idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
      cyc("lduse_r0", O_NORM);
      idex_wsel = 5'd3; ifid_rs = 5'd4; ifid_rt = 5'd6;
      cyc("lduse_nomatch", O_NORM);
      clear_in();

      // branch wins over lduse and !ihit; dwait wins over branch
      exmem_brtaken = 1'b1; idex_MemToReg = 1'b1; idex_wsel = 5'd2;
      ifid_rs = 5'd2; ihit = 1'b0;
      cyc("br_over_all", O_BR);
      exmem_dREN = 1'b1;
      cyc("dwait_over_br", O_FRZ);
      dhit = 1'b1;
      cyc("br_on_dhit", O_BR);
      exmem_brtaken = 1'b0; exmem_dREN = 1'b0; dhit = 1'b0;
      cyc("lduse_over_noihit", O_LDU);
      idex_MemToReg = 1'b0;
      cyc("noihit", O_NOI);
      clear_in();

      // halt drain to HALTED
      idex_halt = 1'b1;
      cyc("halt_in_ex", O_NORM);
      idex_halt = 1'b0;
      cyc("drain0", O_DRAIN);
      exmem_dREN = 1'b1;
      cyc("drain_dwait", O_FRZ);
      exmem_dREN = 1'b0;
      cyc("drain1", O_DRAIN);
      memwb_halt = 1'b1;
      cyc("drain_wb", O_DRAIN);
      memwb_halt = 1'b0;
      cyc("halted0", O_HALT);
      exmem_brtaken = 1'b1; exmem_dREN = 1'b1;
      cyc("halted_sticky", O_HALT);
      clear_in();
      cyc("halted_sticky2", O_HALT);
      nRST = 1'b0;
      cyc("rst_halted", O_RST);
      nRST = 1'b1;
      cyc("run_after_halt", O_NORM);

      // older branch squashes the halt while draining
      idex_halt = 1'b1;
      cyc("halt_in_ex2", O_NORM);
      idex_halt = 1'b0; exmem_brtaken = 1'b1;
      cyc("drain_br", O_BR);
      exmem_brtaken = 1'b0;
      cyc("back_to_run", O_NORM);
      cyc("back_to_run2", O_NORM);

      // halt blocked by dwait stays in RUN
      idex_halt = 1'b1; exmem_dREN = 1'b1;
      cyc("halt_dwait", O_FRZ);
      exmem_dREN = 1'b0; idex_halt = 1'b0;
      cyc("halt_dwait_run", O_NORM);

      // memwb_halt straight from RUN
      memwb_halt = 1'b1;
      cyc("wb_halt_run", O_NORM);
      memwb_halt = 1'b0;
      cyc("wb_halt_halted", O_HALT);

      // reset mid-DRAIN
      nRST = 1'b0;
      cyc("rst2", O_RST);
      nRST = 1'b1; idex_halt = 1'b1;
      cyc("halt_in_ex3", O_NORM);
      idex_halt = 1'b0; nRST = 1'b0;
      cyc("rst_in_drain", O_RST);
      nRST = 1'b1;
      cyc("run_after_drain_rst", O_NORM);

`ifdef PIPE_PERF_CNT_EN
      nRST = 1'b0;
      cyc("perf_rst", O_RST);
      nRST = 1'b1; exmem_dREN = 1'b1;
      cyc("perf_dw0", O_FRZ);
      cyc("perf_dw1", O_FRZ);
      cyc("perf_dw2", O_FRZ);
      dhit = 1'b1;
      cyc("perf_dhit", O_NORM);
      clear_in();
      idex_MemToReg = 1'b1; idex_wsel = 5'd9; ifid_rs = 5'd9;
      cyc("perf_ldu", O_LDU);
      clear_in();
      exmem_brtaken = 1'b1;
      cyc("perf_br", O_BR);
      clear_in();
      @(negedge CLK);
      checks++;
      assert (stall_cnt === 32'd4) else begin
         failures++;
         $error("FAIL stall_cnt observed=%0d expected=4", stall_cnt);
      end
      checks++;
      assert (flush_cnt === 32'd1) else begin
         failures++;
         $error("FAIL flush_cnt observed=%0d expected=1", flush_cnt);
      end
      checks++;
      assert (cyc_cnt === 32'd6) else begin
         failures++;
         $error("FAIL cyc_cnt observed=%0d expected=6", cyc_cnt);
      end
      @(posedge CLK);
      #1;
`endif

      checks++;
      assert (sb_q.size() == 0) else begin
         failures++;
         $error("FAIL scoreboard_empty observed=%0d expected=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard/sequencing controller for the 5-stage pipeline. Generates the en/flush pair for each of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the PC write enable. Handles data-memory wait, instruction-memory wait, load-use stall, taken-branch squash and halt drain through a small FSM. Sits beside the datapath. Its outputs drive the latches' en/flush inputs directly; in every latch, flush has priority over en.

Parameters:
REG_W, 5, register index width
CNT_W, 32, width of optional performance counters

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, synchronous, active-low
ihit  in  1  instruction memory returned valid word this cycle
dhit  in  1  data memory completed access this cycle
exmem_dREN  in  1  EX/MEM latch output: load in MEM stage
exmem_dWEN  in  1  EX/MEM latch output: store in MEM stage
exmem_brtaken  in  1  branch/jump resolved taken in MEM stage
idex_MemToReg  in  1  ID/EX output: instruction in EX is a load
idex_wsel  in  REG_W  ID/EX output: destination register
ifid_rs  in  REG_W  IF/ID output: source register rs
ifid_rt  in  REG_W  IF/ID output: source register rt
idex_halt  in  1  ID/EX output: halt in EX stage
memwb_halt  in  1  MEM/WB output: halt reached WB
pc_en  out  1  PC update enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flushes
halted  out  1  core stopped, sticky

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Registered on CLK. While nRST=0 at an edge, the next state is RUN.
- Outputs are combinational from state and inputs. While nRST=0: all en=0, all flush=1, pc_en=0, halted=0.
- dwait = (exmem_dREN|exmem_dWEN) & !dhit.
- lduse = idex_MemToReg & idex_wsel!=0 & (idex_wsel==ifid_rs | idex_wsel==ifid_rt).
- RUN, priority order (highest first):
  1. dwait: all en=0, all flush=0, pc_en=0. Freeze the whole pipe; no instruction lost.
  2. exmem_brtaken: pc_en=1; ifid_flush=idex_flush=exmem_flush=1; memwb_en=1. The branch retires normally.
  3. lduse: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. Exactly one bubble per load-use pair.
  4. !ihit: pc_en=0, ifid_flush=1, idex_en=exmem_en=memwb_en=1.
  5. Otherwise: all en=1, pc_en=1, no flush.
- RUN -> DRAIN when idex_halt=1 and no dwait and no exmem_brtaken.
- DRAIN:
  - pc_en=0, ifid_flush=1, idex_flush=1, exmem_en=memwb_en=1. Younger instructions are squashed; the halt advances.
  - dwait overrides with a full freeze.
  - exmem_brtaken (an older branch squashes the halt) -> RUN with the branch flush pattern.
  - memwb_halt=1 -> HALTED.
- HALTED: all en=0, all flush=0, pc_en=0, halted=1. Remains until reset.
- Simultaneous events:
  - dwait + brtaken: freeze this cycle; the branch is acted on in the cycle dhit arrives.
  - lduse + !ihit: lduse pattern.
  - memwb_halt in RUN (halt bypassed DRAIN because of a flush race) -> HALTED.
- Reset mid-stall or mid-DRAIN -> RUN; no residual state.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, add outputs stall_cnt, flush_cnt, cyc_cnt (each CNT_W):
  - cyc_cnt increments every non-HALTED cycle.
  - stall_cnt increments on any cycle with pc_en=0 in RUN/DRAIN.
  - flush_cnt increments on each exmem_brtaken flush.
  - All counters clear on reset, saturate at all-ones, and freeze in HALTED.
- When undefined: no counters and no extra ports.

Test Plan:
- Reset then ihit=1, no hazards -> every en=1, pc_en=1, all flush=0, halted=0; after nRST=0 for one edge, all flush=1 and all en=0.
- exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> all en/pc_en=0 for 3 cycles, all en=1 on the dhit cycle.
- idex_MemToReg=1, idex_wsel=5, ifid_rt=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; with idex_wsel=0 -> no stall.
- exmem_brtaken=1 with lduse and !ihit also true -> ifid/idex/exmem_flush=1, memwb_en=1, pc_en=1; same cycle with dwait -> full freeze.
- idex_halt=1 -> DRAIN: pc_en=0 and ifid/idex_flush=1; memwb_halt=1 two cycles later -> halted=1 sticky; exmem_brtaken in DRAIN -> back to RUN, halted stays 0.
- PIPE_PERF_CNT_EN: 3-cycle dwait + 1 load-use + 1 branch -> stall_cnt=4, flush_cnt=1.
